// File: rtl/ex_pkg.sv
// Shared types for the execute-resolve stage: result-op encoding, branch
// funct3 codes and the writeback/branch packet carried to the memory stage.
package ex_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RES_PASS   = 2'b00,
    RES_SLT    = 2'b01,
    RES_SLTU   = 2'b10,
    RES_BRANCH = 2'b11
  } res_op_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [4:0]      rd;
    logic            reg_write;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
  } ex_pkt_t;

endpackage

// File: rtl/branch_cond.sv
// Branch comparison from the flags of an A-B subtract. Carry means "no borrow",
// so unsigned less-than is its inverse; signed less-than corrects N by overflow.
module branch_cond
  import ex_pkg::*;
(
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_negative,
  input  logic       alu_result_msb,
  input  logic       op_a_msb,
  input  logic       op_b_msb,
  input  logic [2:0] funct3,
  output logic       eq,
  output logic       lt,
  output logic       ltu,
  output logic       taken
);

  logic ovf;

  assign ovf = (op_a_msb != op_b_msb) & (alu_result_msb != op_a_msb);
  assign lt  = alu_negative ^ ovf;
  assign ltu = ~alu_carry;
  assign eq  = alu_zero;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = ~lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_resolve_stage.sv
// Execute-resolve stage: completes SLT/SLTU, resolves branches and registers the
// packet toward memory. EX_RESOLVE_SKID_EN selects a 2-entry skid buffer.
module ex_resolve_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_negative,
  input  logic        op_a_msb,
  input  logic        op_b_msb,
  input  logic [1:0]  res_op,
  input  logic [2:0]  br_funct3,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  input  logic [31:0] br_target,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_br_taken,
  output logic [31:0] out_br_target
);

  res_op_t op;
  logic    eq_unused, lt, ltu, taken;
  ex_pkt_t pkt_d;
  ex_pkt_t main_q;
  logic    main_valid_q;
  logic    acc, drn;

  assign op = res_op_t'(res_op);

  branch_cond u_branch_cond (
    .alu_carry      (alu_carry),
    .alu_zero       (alu_zero),
    .alu_negative   (alu_negative),
    .alu_result_msb (alu_result[31]),
    .op_a_msb       (op_a_msb),
    .op_b_msb       (op_b_msb),
    .funct3         (br_funct3),
    .eq             (eq_unused),
    .lt             (lt),
    .ltu            (ltu),
    .taken          (taken)
  );

  always_comb begin
    pkt_d           = '0;
    pkt_d.result    = alu_result;
    pkt_d.rd        = rd;
    pkt_d.reg_write = reg_write;
    pkt_d.br_target = br_target;
    case (op)
      RES_SLT:  pkt_d.result = {31'b0, lt};
      RES_SLTU: pkt_d.result = {31'b0, ltu};
      RES_BRANCH: begin
        pkt_d.reg_write = 1'b0;
        pkt_d.br_taken  = taken;
      end
      default: ;
    endcase
  end

  assign acc = in_valid & in_ready;
  assign drn = main_valid_q & out_ready;

`ifdef EX_RESOLVE_SKID_EN
  ex_pkt_t skid_q;
  logic    skid_valid_q;

  // Ready comes straight from a flop, isolating upstream from out_ready timing.
  assign in_ready = ~skid_valid_q;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!main_valid_q) begin
      if (acc) begin
        main_q       <= pkt_d;
        main_valid_q <= 1'b1;
      end
    end else if (!skid_valid_q) begin
      if (acc && drn) begin
        main_q <= pkt_d;
      end else if (acc) begin
        skid_q       <= pkt_d;
        skid_valid_q <= 1'b1;
      end else if (drn) begin
        main_valid_q <= 1'b0;
      end
    end else if (drn) begin
      main_q       <= skid_q;
      skid_valid_q <= 1'b0;
    end
  end
`else
  assign in_ready = ~main_valid_q | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
    end else if (flush) begin
      main_valid_q <= 1'b0;
    end else if (acc) begin
      main_q       <= pkt_d;
      main_valid_q <= 1'b1;
    end else if (drn) begin
      main_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid     = main_valid_q;
  assign out_result    = main_q.result;
  assign out_rd        = main_q.rd;
  assign out_reg_write = main_q.reg_write;
  assign out_br_taken  = main_q.br_taken;
  assign out_br_target = main_q.br_target;

endmodule

// File: tb/tb_ex_resolve_stage.sv
// Self-checking bench for ex_resolve_stage: directed test-plan steps followed by
// random traffic, all compared against a queue-based reference model.
module tb_ex_resolve_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] alu_result;
  logic        alu_carry, alu_zero, alu_negative, op_a_msb, op_b_msb;
  logic [1:0]  res_op;
  logic [2:0]  br_funct3;
  logic [4:0]  rd;
  logic        reg_write;
  logic [31:0] br_target;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_br_taken;
  logic [31:0] out_br_target;

  ex_resolve_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_negative(alu_negative), .op_a_msb(op_a_msb), .op_b_msb(op_b_msb),
    .res_op(res_op), .br_funct3(br_funct3), .rd(rd), .reg_write(reg_write),
    .br_target(br_target), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_br_taken(out_br_taken),
    .out_br_target(out_br_target)
  );

  always #5 clk = ~clk;

  ex_pkt_t q[$];
  ex_pkt_t cur;
  int      n_cmp = 0;
  int      n_fail = 0;
  bit      last_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned comparisons on the original operands.
  function automatic ex_pkt_t ref_pkt(input res_op_t op, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [4:0] r, input logic rw,
                                      input logic [31:0] tgt);
    ex_pkt_t p;
    bit lt  = $signed(a) < $signed(b);
    bit ltu = a < b;
    bit eq  = a == b;
    p.result    = a - b;
    p.rd        = r;
    p.reg_write = rw;
    p.br_taken  = 1'b0;
    p.br_target = tgt;
    case (op)
      RES_SLT:  p.result = lt  ? 32'd1 : 32'd0;
      RES_SLTU: p.result = ltu ? 32'd1 : 32'd0;
      RES_BRANCH: begin
        p.reg_write = 1'b0;
        case (f3)
          3'b000:  p.br_taken = eq;
          3'b001:  p.br_taken = !eq;
          3'b100:  p.br_taken = lt;
          3'b101:  p.br_taken = !lt;
          3'b110:  p.br_taken = ltu;
          3'b111:  p.br_taken = !ltu;
          default: p.br_taken = 1'b0;
        endcase
      end
      default: ;
    endcase
    return p;
  endfunction

  function automatic bit model_ready();
`ifdef EX_RESOLVE_SKID_EN
    return q.size() < 2;
`else
    return q.size() == 0 || out_ready;
`endif
  endfunction

  task automatic drive(input res_op_t op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r, input logic rw,
                       input logic [31:0] tgt);
    logic [31:0] diff;
    diff         = a - b;
    alu_result   = diff;
    alu_carry    = (a >= b);
    alu_zero     = (a == b);
    alu_negative = diff[31];
    op_a_msb     = a[31];
    op_b_msb     = b[31];
    res_op       = op;
    br_funct3    = f3;
    rd           = r;
    reg_write    = rw;
    br_target    = tgt;
    cur          = ref_pkt(op, f3, a, b, r, rw, tgt);
  endtask

  task automatic drive_rand();
    logic [31:0] a, b;
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    drive(res_op_t'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), a, b,
          5'($urandom), 1'($urandom), $urandom);
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(model_ready()));
    if (q.size() > 0) begin
      check("out_result", out_result, q[0].result);
      check("out_rd", 32'(out_rd), 32'(q[0].rd));
      check("out_reg_write", 32'(out_reg_write), 32'(q[0].reg_write));
      check("out_br_taken", 32'(out_br_taken), 32'(q[0].br_taken));
      check("out_br_target", out_br_target, q[0].br_target);
    end
  endtask

  // One clock: compare at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    bit acc, drn, fl;
    @(negedge clk);
    check_outputs();
    acc = in_valid && model_ready();
    drn = (q.size() > 0) && out_ready;
    fl  = flush;
    @(posedge clk);
    last_acc = 1'b0;
    if (fl) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(cur);
        last_acc = 1'b1;
      end
    end
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_result"}, out_result, 32'd0);
    check({tag, "_out_rd"}, 32'(out_rd), 32'd0);
    check({tag, "_out_reg_write"}, 32'(out_reg_write), 32'd0);
    check({tag, "_out_br_taken"}, 32'(out_br_taken), 32'd0);
    check({tag, "_out_br_target"}, out_br_target, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit accepted;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    drive(RES_PASS, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();

    // BEQ equal
    out_ready = 1'b1; in_valid = 1'b1;
    drive(RES_BRANCH, F3_BEQ, 32'd5, 32'd5, 5'd3, 1'b1, 32'h100);
    cycle();
    check("beq_taken", 32'(out_br_taken), 32'd1);
    check("beq_target", out_br_target, 32'h100);
    check("beq_reg_write", 32'(out_reg_write), 32'd0);

    // SLT / SLTU with A=-1, B=1
    drive(RES_SLT, 3'b000, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1, 32'd0);
    cycle();
    check("slt_result", out_result, 32'd1);
    drive(RES_SLTU, 3'b000, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 32'd0);
    cycle();
    check("sltu_result", out_result, 32'd0);

    // Signed overflow on the subtract
    drive(RES_BRANCH, F3_BLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h40);
    cycle();
    check("ovf_blt", 32'(out_br_taken), 32'd0);
    drive(RES_BRANCH, F3_BGE, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h44);
    cycle();
    check("ovf_bge", 32'(out_br_taken), 32'd1);
    drive(RES_BRANCH, F3_BLTU, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h48);
    cycle();
    check("ovf_bltu", 32'(out_br_taken), 32'd1);
    in_valid = 1'b0;
    cycle();
    cycle();

    // Backpressure: three back-to-back offers with the sink stalled
    out_ready = 1'b0; in_valid = 1'b1;
    drive_rand(); cycle();
    drive_rand(); cycle();
    drive_rand(); cycle();
`ifdef EX_RESOLVE_SKID_EN
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
`else
    check("bp_in_ready_follows", 32'(in_ready), 32'(out_ready));
`endif
    cycle();
    out_ready = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 8 && !accepted; i++) begin
      cycle();
      if (last_acc) begin
        accepted = 1'b1;
        in_valid = 1'b0;
      end
    end
    check("bp_third_accepted", 32'(accepted), 32'd1);
    for (int i = 0; i < 4; i++) cycle();

    // Flush while holding entries with a valid input present
    out_ready = 1'b0; in_valid = 1'b1;
    drive_rand(); cycle();
    drive_rand(); cycle();
    flush = 1'b1;
    drive_rand();
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Asynchronous reset in the middle of a stalled stream
    out_ready = 1'b0; in_valid = 1'b1;
    drive_rand(); cycle();
    drive_rand(); cycle();
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_values("midreset");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cycle();
    cycle();

`ifndef EX_RESOLVE_SKID_EN
    // Without the skid buffer, ready tracks out_ready while MAIN is occupied
    in_valid = 1'b1; drive_rand(); cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("nskid_ready_low", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    check("nskid_ready_high", 32'(in_ready), 32'd1);
    cycle();
`endif

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      drive_rand();
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_resolve_stage.md
# ex_resolve_stage

Execute-resolve stage directly downstream of the 32-bit ALU. Captures the ALU result and flags (Carry/Zero/Negative) for one instruction per handshake, completes the operations the ALU lacks (SLT/SLTU from a subtract), and resolves conditional branches from the flags. It then presents a registered writeback/branch packet to the memory stage through a valid/ready interface with a 2-entry skid buffer.

## Interface
- No parameters; widths fixed at XLEN=32, register index 5.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1 / `in_ready` out 1: upstream handshake; transfer when both high.
- `alu_result` in 32; `alu_carry`, `alu_zero`, `alu_negative` in 1: ALU outputs for this instruction.
- `op_a_msb`, `op_b_msb` in 1: bit 31 of the ALU A and B inputs, before any B inversion.
- `res_op` in 2: 00 PASS, 01 SLT, 10 SLTU, 11 BRANCH.
- `br_funct3` in 3: RISC-V branch funct3; used only when `res_op`=BRANCH.
- `rd` in 5; `reg_write` in 1; `br_target` in 32: these pass through with the instruction.
- `flush` in 1: kill all held and incoming instructions.
- `out_valid` out 1 / `out_ready` in 1: downstream handshake.
- `out_result` out 32; `out_rd` out 5; `out_reg_write` out 1; `out_br_taken` out 1; `out_br_target` out 32.

## Operation
- SLT, SLTU and BRANCH require the ALU to have been driven with Control=001 (A−B). Carry then means "no borrow".
- Derived signals:
  - V = (op_a_msb ≠ op_b_msb) & (alu_result[31] ≠ op_a_msb)
  - lt = alu_negative ^ V
  - ltu = ~alu_carry
  - eq = alu_zero
- Result by `res_op`:
  - PASS: `alu_result`.
  - SLT: {31'b0, lt}.
  - SLTU: {31'b0, ltu}.
  - BRANCH: `alu_result`, with `out_reg_write` forced to 0.
- Branch taken, by funct3: 000 eq; 001 ~eq; 100 lt; 101 ~lt; 110 ltu; 111 ~ltu.
  - funct3 010/011: not taken.
  - Non-BRANCH ops: not taken.
- `out_br_target` is a pass-through of `br_target`.
- Storage is two entries: MAIN, which drives the outputs, and SKID.
- States:
  - EMPTY: MAIN invalid, SKID invalid.
  - ONE: MAIN valid, SKID invalid.
  - FULL: MAIN valid, SKID valid.
- `in_ready` = ~SKID.valid. It is registered and has no combinational path from `out_ready`.
- Transitions (acc = input accepted, drn = `out_valid & out_ready`):
  - EMPTY: acc → ONE (load MAIN).
  - ONE: acc & ~drn → FULL (load SKID); acc & drn → ONE (load MAIN); ~acc & drn → EMPTY.
  - FULL: drn → ONE (SKID moves to MAIN); otherwise hold.
- `flush` has priority over every other event. The next state is EMPTY, and any input presented in the flush cycle is dropped even if `in_valid & in_ready`.
- Ordering is strictly FIFO.

## Timing
- Latency is 1 cycle: an input accepted at edge N appears on `out_*` with `out_valid`=1 after edge N.
- Throughput is 1 per cycle while `out_ready`=1.
- Output data is stable while `out_valid & ~out_ready`.
- Reset values: `out_valid`=0, `in_ready`=1, `out_result`=0, `out_rd`=0, `out_reg_write`=0, `out_br_taken`=0, `out_br_target`=0. Both entries are invalid.
- Reset asserted mid-transfer discards all held entries immediately (asynchronous).
- Flag and result derivation is combinational on the input side and is captured at acceptance. No output depends combinationally on `in_*`.

## Configuration
- `EX_RESOLVE_SKID_EN` defined: the 2-entry skid behaviour described above, with registered `in_ready`.
- Not defined: MAIN only, with `in_ready` = ~MAIN.valid | `out_ready` (combinational).
  - Same 1-cycle latency and full throughput.
  - FULL state does not exist.
  - Flush and reset rules are unchanged.

## Structure
- Package `ex_pkg` holds:
  - `res_op_t` enum: PASS/SLT/SLTU/BRANCH.
  - funct3 constants: BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - Packed struct `ex_pkt_t`: result, rd, reg_write, br_taken, br_target.
- Sub-module `branch_cond`: combinational. Inputs are the flags, the operand MSBs and funct3; outputs are eq/lt/ltu/taken. It is instantiated once, before the storage.

## Test plan
- **BEQ equal:** A=5, B=5 → `alu_result`=0, zero=1, funct3=000, `br_target`=0x100 → next cycle `out_br_taken`=1, `out_br_target`=0x100, `out_reg_write`=0.
- **SLT / SLTU, A=0xFFFFFFFF, B=1:** `alu_result`=0xFFFFFFFE, N=1, carry=1 → SLT gives `out_result`=1; SLTU gives `out_result`=0.
- **Overflow, A=0x7FFFFFFF, B=0xFFFFFFFF:** `alu_result`=0x80000000, N=1, V=1 → BLT not taken, BGE taken, BLTU taken.
- **Backpressure:** three back-to-back inputs with `out_ready`=0 → two accepted, `in_ready`=0 on the third. Raise `out_ready` → outputs drain in order and the third is accepted the cycle after `in_ready` returns to 1.
- **Flush:** flush in FULL with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, and the flushed-cycle input never appears.
- **Reset:** `rst_n` pulsed low mid-stream → outputs at their reset values immediately, no stale packet after release. Also run with `EX_RESOLVE_SKID_EN` undefined and check that `in_ready` follows `out_ready`.
